alu_multicycle: RTL and testbench

//  Parametrised, handshaked successor to the 32-bit combinational ALU.
//  - Executes the 16-op set: logic, shifts, unsigned and signed add/sub, set-less-than, CLO and CLZ.
//  - Registers the result and the NZCV flags.
//  - Variable shifts and CLO/CLZ can run iteratively, one bit per cycle, to save area.
//  - Sits between the register-read stage and the writeback stage; valid/ready on both sides.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_iter_unit.sv | 81 ++++++++
 rtl/alu_multicycle.sv | 182 ++++++++++++++++++
 tb/tb_alu_multicycle.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: opcodes, FSM states and
// the operating modes of the iterative shift/count unit.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SLLV = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRLV = 4'd7;
  localparam logic [3:0] OP_ADDU = 4'd8;
  localparam logic [3:0] OP_SUBU = 4'd9;
  localparam logic [3:0] OP_ADD  = 4'd10;
  localparam logic [3:0] OP_SUB  = 4'd11;
  localparam logic [3:0] OP_SLT  = 4'd12;
  localparam logic [3:0] OP_SLTU = 4'd13;
  localparam logic [3:0] OP_CLO  = 4'd14;
  localparam logic [3:0] OP_CLZ  = 4'd15;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  typedef enum logic [1:0] {ITER_SHL, ITER_SHR, ITER_CLO, ITER_CLZ} iter_mode_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Bit-serial shift / leading-count engine. Loaded on start, advances one
// bit per step, and flags the step that completes the operation so the
// caller can capture result and carry on that same edge.
module alu_iter_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   steps,
  output logic             last,
  output logic [WIDTH-1:0] result,
  output logic             carry
);
  import alu_pkg::*;

  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH-1);

  iter_mode_t       mode_q;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic [SHW-1:0]   rem;
  logic [SHW:0]     cnt;
  logic [SHW:0]     cnt_next;
  logic             match;

  // Value the engine will hold after the current step, and whether that step ends the op
  always_comb begin
    sreg_next = sreg;
    cnt_next  = cnt;
    match     = 1'b0;
    last      = 1'b0;
    result    = '0;
    carry     = 1'b0;
    case (mode_q)
      ITER_SHL: begin
        sreg_next = sreg << 1;
        carry     = sreg[WIDTH-1];
        result    = sreg_next;
        last      = (rem == SHW'(1));
      end
      ITER_SHR: begin
        sreg_next = sreg >> 1;
        carry     = sreg[0];
        result    = sreg_next;
        last      = (rem == SHW'(1));
      end
      default: begin
        match     = (sreg[WIDTH-1] == (mode_q == ITER_CLO));
        if (match) cnt_next = cnt + (SHW+1)'(1);
        sreg_next = sreg << 1;
        result    = WIDTH'(cnt_next);
        last      = !match || (cnt == CNT_LAST);
      end
    endcase
  end

  // Load operands on start, otherwise advance one bit per step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= ITER_SHL;
      sreg   <= '0;
      rem    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mode_q <= iter_mode_t'(mode);
      sreg   <= a;
      rem    <= steps;
      cnt    <= '0;
    end else if (step) begin
      sreg <= sreg_next;
      rem  <= rem - SHW'(1);
      cnt  <= cnt_next;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked ALU with registered result and NZCV flags. Simple ops finish
// on the accepting edge; shifts and leading counts optionally run through
// the bit-serial engine.
module alu_multicycle #(
  parameter int WIDTH     = 32,
  parameter int ITERATIVE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_n,
  output logic             out_z,
  output logic             out_c,
  output logic             out_v
);
  import alu_pkg::*;

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

  state_t           state;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   shl_wide;
  logic [WIDTH:0]   shr_wide;
  logic [WIDTH-1:0] comb_result;
  logic             comb_c;
  logic             comb_v;
  logic [SHW:0]     lead;
  logic             lead_done;
  logic             lead_bit;
  logic             op_iter;
  logic             go_iter;
  logic             accept;
  logic [1:0]       iter_mode;
  logic [SHW-1:0]   iter_steps;
  logic             iter_last;
  logic [WIDTH-1:0] iter_result;
  logic             iter_carry;

  assign shamt     = in_b[SHW-1:0];
  assign accept    = (state == ST_IDLE) && in_valid;
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // Leading ones/zeros of operand a, scanning down from the MSB
  always_comb begin
    lead      = '0;
    lead_done = 1'b0;
    lead_bit  = (in_op == OP_CLO);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!lead_done) begin
        if (in_a[i] == lead_bit) lead = lead + CNT_ONE;
        else                     lead_done = 1'b1;
      end
    end
  end

  // Single-cycle datapath: result plus carry and overflow for every opcode
  always_comb begin
    sum         = {1'b0, in_a} + {1'b0, in_b};
    diff        = {1'b0, in_a} - {1'b0, in_b};
    shl_wide    = {1'b0, in_a} << shamt;
    shr_wide    = {in_a, 1'b0} >> shamt;
    comb_result = '0;
    comb_c      = 1'b0;
    comb_v      = 1'b0;
    case (in_op)
      OP_AND:  comb_result = in_a & in_b;
      OP_OR:   comb_result = in_a | in_b;
      OP_XOR:  comb_result = in_a ^ in_b;
      OP_NOR:  comb_result = ~(in_a | in_b);
      OP_SLL:  begin comb_result = in_a << 1; comb_c = in_a[WIDTH-1]; end
      OP_SRL:  begin comb_result = in_a >> 1; comb_c = in_a[0]; end
      OP_SLLV: begin comb_result = shl_wide[WIDTH-1:0]; comb_c = shl_wide[WIDTH]; end
      OP_SRLV: begin comb_result = shr_wide[WIDTH:1]; comb_c = shr_wide[0]; end
      OP_ADDU: begin comb_result = sum[WIDTH-1:0]; comb_c = sum[WIDTH]; end
      OP_ADD: begin
        comb_result = sum[WIDTH-1:0];
        comb_c      = sum[WIDTH];
        comb_v      = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUBU: begin comb_result = diff[WIDTH-1:0]; comb_c = diff[WIDTH]; end
      OP_SUB: begin
        comb_result = diff[WIDTH-1:0];
        comb_c      = diff[WIDTH];
        comb_v      = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SLT:  comb_result = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: comb_result = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      default: comb_result = WIDTH'(lead);
    endcase
  end

  // Decide whether the op goes through the serial engine and how to set it up
  always_comb begin
    op_iter = (in_op == OP_SLL) || (in_op == OP_SRL) || (in_op == OP_SLLV) ||
              (in_op == OP_SRLV) || (in_op == OP_CLO) || (in_op == OP_CLZ);
    go_iter = (ITERATIVE != 0) && op_iter &&
              !(((in_op == OP_SLLV) || (in_op == OP_SRLV)) && (shamt == '0));
    case (in_op)
      OP_SLL, OP_SLLV: iter_mode = ITER_SHL;
      OP_SRL, OP_SRLV: iter_mode = ITER_SHR;
      OP_CLO:          iter_mode = ITER_CLO;
      default:         iter_mode = ITER_CLZ;
    endcase
    iter_steps = ((in_op == OP_SLL) || (in_op == OP_SRL)) ? SHW'(1) : shamt;
  end

  generate
    if (ITERATIVE != 0) begin : g_iter
      alu_iter_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && go_iter),
        .step   (state == ST_BUSY),
        .mode   (iter_mode),
        .a      (in_a),
        .steps  (iter_steps),
        .last   (iter_last),
        .result (iter_result),
        .carry  (iter_carry)
      );
    end else begin : g_no_iter
      assign iter_last   = 1'b0;
      assign iter_result = '0;
      assign iter_carry  = 1'b0;
    end
  endgenerate

  // Handshake FSM; captures result and flags on the edge the op completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      out_result <= '0;
      out_n      <= 1'b0;
      out_z      <= 1'b0;
      out_c      <= 1'b0;
      out_v      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (go_iter) begin
              state <= ST_BUSY;
            end else begin
              out_result <= comb_result;
              out_n      <= comb_result[WIDTH-1];
              out_z      <= (comb_result == '0);
              out_c      <= comb_c;
              out_v      <= comb_v;
              state      <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          if (iter_last) begin
            out_result <= iter_result;
            out_n      <= iter_result[WIDTH-1];
            out_z      <= (iter_result == '0);
            out_c      <= iter_carry;
            out_v      <= 1'b0;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: an iterative and a single-cycle instance run
// side by side on the same operations, checked against a table of known
// vectors, handshake/reset sequences and a reference model on random ops.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   in_op = '0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;

  logic         it_in_ready, it_out_valid, it_n, it_z, it_c, it_v;
  logic [W-1:0] it_result;
  logic         sc_in_ready, sc_out_valid, sc_n, sc_z, sc_c, sc_v;
  logic [W-1:0] sc_result;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  nzcv;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  alu_multicycle #(.WIDTH(W), .ITERATIVE(1)) dut_it (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(it_in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(it_out_valid),
    .out_ready(out_ready), .out_result(it_result),
    .out_n(it_n), .out_z(it_z), .out_c(it_c), .out_v(it_v)
  );

  alu_multicycle #(.WIDTH(W), .ITERATIVE(0)) dut_sc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sc_in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(sc_out_valid),
    .out_ready(out_ready), .out_result(sc_result),
    .out_n(sc_n), .out_z(sc_z), .out_c(sc_c), .out_v(sc_v)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Guard against a stuck simulation
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference behaviour: plain arithmetic on the opcode rules; lat is the
  // number of samples after the accepting edge until out_valid for ITERATIVE=1
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic [3:0] nzcv, output int lat);
    logic        c;
    logic        v;
    logic [63:0] u;
    longint      s64;
    int          s;
    int          cnt;
    logic        lb;
    c = 1'b0;
    v = 1'b0;
    lat = 1;
    res = '0;
    s = int'(b[4:0]);
    case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOR: res = ~(a | b);
      OP_SLL: begin res = a << 1; c = a[31]; lat = 2; end
      OP_SRL: begin res = a >> 1; c = a[0]; lat = 2; end
      OP_SLLV: begin res = a << s; c = (s == 0) ? 1'b0 : a[32 - s]; lat = s + 1; end
      OP_SRLV: begin res = a >> s; c = (s == 0) ? 1'b0 : a[s - 1]; lat = s + 1; end
      OP_ADDU, OP_ADD: begin
        u = {32'b0, a} + {32'b0, b};
        res = u[31:0];
        c = u[32];
        if (op == OP_ADD) begin
          s64 = longint'($signed(a)) + longint'($signed(b));
          v = (s64 > 64'sd2147483647) || (s64 < -64'sd2147483648);
        end
      end
      OP_SUBU, OP_SUB: begin
        res = a - b;
        c = (a < b);
        if (op == OP_SUB) begin
          s64 = longint'($signed(a)) - longint'($signed(b));
          v = (s64 > 64'sd2147483647) || (s64 < -64'sd2147483648);
        end
      end
      OP_SLT:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: res = (a < b) ? 32'd1 : 32'd0;
      default: begin
        lb = (op == OP_CLO);
        cnt = 0;
        while (cnt < 32 && a[31 - cnt] == lb) cnt++;
        res = 32'(cnt);
        lat = ((cnt + 1 < 32) ? cnt + 1 : 32) + 1;
      end
    endcase
    nzcv = {res[31], (res == 32'd0), c, v};
  endfunction

  // Issue one op to both instances, check latency, result and flags, then retire it
  task automatic apply_stimulus(input string tag, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp_res,
                                input logic [3:0] exp_nzcv, input int exp_lat);
    int lat_it;
    int lat_sc;
    in_op = op;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    in_op = 4'($urandom);
    lat_it = 0;
    lat_sc = 0;
    for (int k = 1; k <= 40; k++) begin
      if (it_out_valid && lat_it == 0) lat_it = k;
      if (sc_out_valid && lat_sc == 0) lat_sc = k;
      if (lat_it != 0 && lat_sc != 0) break;
      tick();
    end
    check_output({tag, " it latency"}, 32'(lat_it), 32'(exp_lat));
    check_output({tag, " sc latency"}, 32'(lat_sc), 32'd1);
    check_output({tag, " it result"}, it_result, exp_res);
    check_output({tag, " it nzcv"}, {28'b0, it_n, it_z, it_c, it_v}, {28'b0, exp_nzcv});
    check_output({tag, " sc result"}, sc_result, exp_res);
    check_output({tag, " sc nzcv"}, {28'b0, sc_n, sc_z, sc_c, sc_v}, {28'b0, exp_nzcv});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output({tag, " idle after handshake"},
                 {28'b0, it_in_ready, it_out_valid, sc_in_ready, sc_out_valid}, 32'b1010);
  endtask

  initial begin
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] m_res;
    logic [3:0]  m_nzcv;
    logic [3:0]  r_op;
    int          m_lat;

    vecs[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1};
    vecs[1]  = '{OP_SUBU, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1010, 1};
    vecs[2]  = '{OP_ADDU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 1};
    vecs[3]  = '{OP_SLLV, 32'h18000001, 32'h00000024, 32'h80000010, 4'b1010, 5};
    vecs[4]  = '{OP_SRLV, 32'h12345678, 32'h00000000, 32'h12345678, 4'b0000, 1};
    vecs[5]  = '{OP_CLZ,  32'h00100000, 32'h00000000, 32'h0000000B, 4'b0000, 13};
    vecs[6]  = '{OP_CLO,  32'hFFFFFFFF, 32'h00000000, 32'h00000020, 4'b0000, 33};
    vecs[7]  = '{OP_CLZ,  32'h00000000, 32'h00000000, 32'h00000020, 4'b0000, 33};
    vecs[8]  = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001, 1};
    vecs[9]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 1};
    vecs[10] = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0100, 1};
    vecs[11] = '{OP_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b1000, 1};
    vecs[12] = '{OP_SRL,  32'h00000003, 32'h00000000, 32'h00000001, 4'b0010, 2};
    vecs[13] = '{OP_SLL,  32'h80000000, 32'h00000000, 32'h00000000, 4'b0110, 2};
    vecs[14] = '{OP_CLO,  32'hF0000000, 32'h00000000, 32'h00000004, 4'b0000, 6};
    vecs[15] = '{OP_SRLV, 32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000, 32};

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check_output("reset it outputs", {it_result[27:0], it_n, it_z, it_c, it_v}, 32'h0);
    check_output("reset sc outputs", {sc_result[27:0], sc_n, sc_z, sc_c, sc_v}, 32'h0);
    check_output("reset handshake",
                 {28'b0, it_in_ready, it_out_valid, sc_in_ready, sc_out_valid}, 32'b1010);

    // Directed vectors
    for (int i = 0; i < 16; i++) begin
      apply_stimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                     vecs[i].res, vecs[i].nzcv, vecs[i].lat);
    end

    // Upper bits of b ignored by a variable shift
    apply_stimulus("srlv upper b", OP_SRLV, 32'h80000000, 32'hFFFFFFE1, 32'h40000000, 4'b0000, 2);

    // Backpressure: result held, no new accept while out_ready is low
    in_op = OP_AND;
    in_a = 32'hF0F0F0F0;
    in_b = 32'hFF00FF00;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = 32'h0;
    in_b = 32'h0;
    for (int k = 0; k < 5; k++) begin
      check_output("bp it result", it_result, 32'hF000F000);
      check_output("bp sc result", sc_result, 32'hF000F000);
      check_output("bp handshake",
                   {28'b0, it_in_ready, it_out_valid, sc_in_ready, sc_out_valid}, 32'b0101);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output("bp ready after handshake",
                 {28'b0, it_in_ready, it_out_valid, sc_in_ready, sc_out_valid}, 32'b1010);

    // Reset in the middle of a long shift
    in_op = OP_SLLV;
    in_a = 32'h00000001;
    in_b = 32'd31;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    in_op = OP_ADD;
    in_valid = 1'b1;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    check_output("midreset it outputs", {it_result[27:0], it_n, it_z, it_c, it_v}, 32'h0);
    check_output("midreset sc outputs", {sc_result[27:0], sc_n, sc_z, sc_c, sc_v}, 32'h0);
    check_output("midreset handshake",
                 {28'b0, it_in_ready, it_out_valid, sc_in_ready, sc_out_valid}, 32'b1010);
    apply_stimulus("post reset add", OP_ADD, 32'h00000005, 32'hFFFFFFFD, 32'h00000002, 4'b0010, 1);

    // Random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a = $urandom;
      r_b = $urandom;
      if (r_op == OP_CLZ) r_a = r_a >> $urandom_range(0, 31);
      if (r_op == OP_CLO) r_a = ~(r_a >> $urandom_range(0, 31));
      model(r_op, r_a, r_b, m_res, m_nzcv, m_lat);
      apply_stimulus($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, r_b, m_res, m_nzcv, m_lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
